// File: rtl/branch_compare_seq_pkg.sv
// Shared definitions for the iterative branch-condition comparator:
// flag bit indices, FSM state encoding and a flag-vector encoder.
package branch_compare_seq_pkg;

    // Flag bit positions within bc_flags
    localparam int unsigned BC_FLAG_GT    = 0;
    localparam int unsigned BC_FLAG_EQ    = 1;
    localparam int unsigned BC_FLAG_LT    = 2;
    localparam int unsigned BC_FLAG_COUNT = 3;

    typedef logic [BC_FLAG_COUNT-1:0] bc_flags_t;

    typedef enum logic [1:0] {
        BCS_IDLE = 2'd0,
        BCS_RUN  = 2'd1,
        BCS_DONE = 2'd2
    } bcs_state_e;

    // One-hot flag vector from a slice result; eq takes priority over gt
    function automatic bc_flags_t bc_flags_encode(input logic eq, input logic gt);
        bc_flags_t f;
        f = '0;
        if (eq) begin
            f[BC_FLAG_EQ] = 1'b1;
        end else if (gt) begin
            f[BC_FLAG_GT] = 1'b1;
        end else begin
            f[BC_FLAG_LT] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/branch_compare_seq_slice_cmp.sv
// bc_slice_cmp: combinational unsigned compare of one SLICE-bit slice.
// Ports: a, b  - slice operands
//        eq    - a == b
//        gt    - a > b (unsigned); meaningful only when eq is low
module bc_slice_cmp #(
    parameter int unsigned SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             gt
);

    logic [SLICE-1:0] w_diff;

    assign w_diff = a ^ b;
    assign eq     = ~|w_diff;

    // Highest differing bit decides; later (higher) iterations overwrite lower ones
    always_comb begin
        gt = 1'b0;
        for (int i = 0; i < int'(SLICE); i++) begin
            if (w_diff[i]) begin
                gt = a[i];
            end
        end
    end

endmodule

// File: rtl/branch_compare_seq.sv
// branch_compare_seq: iterative MSB-first comparator producing GT/EQ/LT
// branch flags, SLICE bits per cycle, with early exit on the first
// differing slice.
// Ports: clk, rst_n    - clock, async active-low reset
//        start         - request compare (accepted when not busy)
//        a, b          - operands, sampled on the accepting edge
//        signed_mode   - 1 = two's-complement compare
//        busy          - compare in progress
//        done          - one-cycle pulse, bc_flags valid from here on
//        bc_flags      - {LT, EQ, GT} one-hot result, held between compares
module branch_compare_seq
    import branch_compare_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     signed_mode,
    output logic                     busy,
    output logic                     done,
    output logic [BC_FLAG_COUNT-1:0] bc_flags
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    // Reject illegal slicing at elaboration
    generate
        if ((SLICE == 0) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_err
            $error("branch_compare_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    bcs_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    bc_flags_t        r_flags;

    logic             w_flip;
    logic [SLICE-1:0] w_flip_mask;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic             w_eq;
    logic             w_gt;

    // Operands shift left after each equal slice, so the slice under test
    // is always the top SLICE bits. Signed mode flips only the operand MSB,
    // which lives in the top slice at idx 0.
    assign w_flip      = r_signed && (r_idx == '0);
    assign w_flip_mask = SLICE'(w_flip) << (SLICE - 1);
    assign w_a_slice   = r_a[WIDTH-1 -: SLICE] ^ w_flip_mask;
    assign w_b_slice   = r_b[WIDTH-1 -: SLICE] ^ w_flip_mask;

    bc_slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .eq (w_eq),
        .gt (w_gt)
    );

    // Control FSM, operand/index registers and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BCS_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                BCS_IDLE, BCS_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= BCS_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= BCS_IDLE;
                    end
                end
                BCS_RUN: begin
                    if (!w_eq || (r_idx == LAST_IDX)) begin
                        r_flags <= bc_flags_encode(w_eq, w_gt);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= BCS_DONE;
                    end else begin
                        r_a   <= r_a << SLICE;
                        r_b   <= r_b << SLICE;
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= BCS_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bc_flags = r_flags;

endmodule

// File: doc/branch_compare_seq.md
# branch_compare_seq

Parametrised, iterative branch-condition comparator for the WF8 ALU. It compares two operands MSB-first, `SLICE` bits per cycle, in signed or unsigned mode, and terminates early on the first differing slice. It registers GT/EQ/LT flags for the branch unit and holds them until the next accepted compare. It replaces the single-width combinational compare when operand width grows beyond 8 bits and timing closure needs a narrow compare path.

## Interface
- `WIDTH`, 8: operand width in bits; must be a multiple of `SLICE`.
- `SLICE`, 2: bits compared per cycle; 1 ≤ `SLICE` ≤ `WIDTH`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a compare; honoured only when `busy`=0.
- `a` input `WIDTH`: left operand (accumulator side); sampled on the accepting edge.
- `b` input `WIDTH`: right operand; sampled on the accepting edge.
- `signed_mode` input 1: 1 = two's-complement compare, 0 = unsigned; sampled with the operands.
- `busy` output 1: compare in progress; `start` is ignored while high.
- `done` output 1: one-cycle pulse; `bc_flags` are valid from this cycle onward.
- `bc_flags` output `BC_FLAG_COUNT`: `[BC_FLAG_GT]` = a>b, `[BC_FLAG_EQ]` = a==b, `[BC_FLAG_LT]` = a<b. Exactly one bit is set after `done`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE or DONE, `start`=1: latch `a`, `b` and `signed_mode`, clear the slice index, go to RUN. Otherwise, DONE returns to IDLE.
- RUN evaluates slice `idx` (bits `[WIDTH-1-idx*SLICE -: SLICE]`) each cycle:
  - slice unequal: set GT/LT from the slice result, go to DONE;
  - slice equal and last slice: set EQ, go to DONE;
  - otherwise: `idx` increments and the FSM stays in RUN.
- Signed mode inverts only the operand MSB (bit `WIDTH-1`) before the top-slice compare. Lower slices always compare unsigned.
- `bc_flags` change only on the transition into DONE, and hold until the next transition into DONE. Accepting a new `start` does not clear them.
- `start` while in RUN has no effect and is not queued. Operand changes during RUN are ignored.
- Outputs:
  - `busy` = (state == RUN);
  - `done` = (state == DONE).
- Reset at any time, including mid-RUN, forces IDLE with `busy`=0, `done`=0, `bc_flags`=0 and `idx`=0. An in-flight compare is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `bc_flags`=0 (all flags low until the first compare completes).
- Accepting edge E0: `busy` rises after E0.
- The slice at index k is evaluated in the cycle after E(k); its result registers at E(k+1).
- Latency from E0 to `done`=1 is m+1 cycles, where m is the index of the first differing slice. For equal operands, m = `WIDTH/SLICE`-1.
- Defaults: latency is 1–4 cycles.
- Back-to-back: `start` in the DONE cycle is accepted. `done` and the new RUN are then adjacent, with no idle cycle between them.
- Single-slice config (`SLICE`=`WIDTH`): every compare takes exactly 1 cycle.

## Structure
- `params.vh` gains `BC_FLAG_LT` and bumps `BC_FLAG_COUNT` to 3. `BC_FLAG_GT` and `BC_FLAG_EQ` keep their indices.
- The state encoding is declared there as `BCS_IDLE`, `BCS_RUN` and `BCS_DONE`.
- The sub-module `bc_slice_cmp` (combinational, parameter `SLICE`) does the XOR-based slice compare. Outputs: `eq`, `gt`.
- The top level holds the FSM, the operand registers, `idx`, the MSB-invert logic and the flag register.
- Parameter legality (`WIDTH % SLICE == 0`) is checked at elaboration with an initial-block error.

## Test plan
- **Reset:** `rst_n` low → `busy`=0, `done`=0, `bc_flags`=3'b000.
- **Unsigned equal** (defaults): a=8'h5A, b=8'h5A, `signed_mode`=0 → `done` 4 cycles after accept, EQ=1.
- **Unsigned top-slice mismatch:** a=8'h80, b=8'h7F, `signed_mode`=0 → `done` after 1 cycle, GT=1. Same operands with `signed_mode`=1 → LT=1.
- **Lowest-slice mismatch:** a=8'h12, b=8'h13 → `done` after 4 cycles, LT=1. A `start` pulsed mid-RUN is ignored and produces no second `done`.
- **Back-to-back and reset:** `start` in the DONE cycle with a=8'hFF, b=8'h01, signed → accepted immediately, LT=1. Then `rst_n` asserted mid-RUN → all outputs 0 and no `done`.
- **Randomised sweep:** `WIDTH`=16 with `SLICE`=1, 4, 16 → flags match a golden compare; latency equals the index of the first differing slice plus 1.
